// File: rtl/cas_div_arbiter.sv
// cas_div_arbiter: round-robin arbiter and multicycle sequencer for a shared
// combinational CAS divider grid (10b / 5b sign-magnitude). Rev 1.0
`default_nettype none

module cas_div_arbiter #(
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [9:0] req0_x,
  input  logic       req0_xs,
  input  logic [4:0] req0_y,
  input  logic       req0_ys,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [9:0] req1_x,
  input  logic       req1_xs,
  input  logic [4:0] req1_y,
  input  logic       req1_ys,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [4:0] resp_q,
  output logic [4:0] resp_r,
  output logic       resp_qs,
  output logic       resp_rs,
  output logic [1:0] resp_err,
  output logic [9:0] grid_x,
  output logic [4:0] grid_y,
  input  logic [5:0] grid_q,
  input  logic [4:0] grid_r
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic             gnt;
  logic             accept;
  logic [9:0]       sel_x;
  logic             sel_xs;
  logic [4:0]       sel_y;
  logic             sel_ys;
  logic             div_zero;
  logic             ovf;
  logic             unused_grid_q5;

  // Quotient bit 5 can never be set on the non-overflow path.
  assign unused_grid_q5 = grid_q[5];

  always_comb begin
    gnt      = (req0_valid && req1_valid) ? ptr : req1_valid;
    accept   = (state == IDLE) && (req0_valid || req1_valid);
    sel_x    = gnt ? req1_x  : req0_x;
    sel_xs   = gnt ? req1_xs : req0_xs;
    sel_y    = gnt ? req1_y  : req0_y;
    sel_ys   = gnt ? req1_ys : req0_ys;
    div_zero = (sel_y == 5'd0);
    ovf      = (sel_x[9:5] >= sel_y);
  end

  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (div_zero || ovf) ? RESP : SETTLE;
      SETTLE:  if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      cnt      <= '0;
      grid_x   <= '0;
      grid_y   <= '0;
      resp_id  <= 1'b0;
      resp_q   <= '0;
      resp_r   <= '0;
      resp_qs  <= 1'b0;
      resp_rs  <= 1'b0;
      resp_err <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr     <= ~gnt;
            resp_id <= gnt;
            resp_qs <= sel_xs ^ sel_ys;
            resp_rs <= sel_xs;
            if (div_zero || ovf) begin
              // Errors skip the grid entirely; grid inputs keep their old value.
              resp_err <= div_zero ? 2'b01 : 2'b10;
              resp_q   <= '0;
              resp_r   <= '0;
            end else begin
              cnt    <= CNT_W'(SETTLE_CYCLES);
              grid_x <= sel_x;
              grid_y <= sel_y;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            resp_q   <= grid_q[4:0];
            resp_r   <= grid_r;
            resp_err <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
